dht_responder: RTL and testbench
================================

DHT_RESPONDER -- requirements
Module: dht_responder

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100, meaning clk cycles per microsecond.
REQ-002 SHALL have parameter START_MIN_US, default 18000, meaning minimum host start-low width accepted.
REQ-003 SHALL have parameter TURN_US, default 30, meaning line-high gap after the host releases before the responder answers.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port DTH  inout  1  single-wire bus, open-drain: driven 0 or high-Z, never driven 1.
REQ-007 SHALL have port enable  input  1  permits a new frame from IDLE.
REQ-008 SHALL have port sensor_data  input  40  frame payload {hum_int, hum_dec, tmp_int, tmp_dec, chk}.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the final bit's trailing low.
REQ-011 SHALL have port start_err  output  1  one-cycle pulse on a rejected (too short) start pulse.

Function
REQ-012 SHALL sample DTH through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-013 SHALL use one 21-bit cycle counter, saturating at all-ones, cleared on every state change.
REQ-014 SHALL implement states IDLE, START_LOW, START_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, DONE.
REQ-015 IDLE: line released; on synced line low and enable=1, SHALL enter START_LOW; enable=0 keeps IDLE.
REQ-016 START_LOW: count while line low; on line high, count >= START_MIN_US*CLK_MHZ -> START_WAIT, else pulse start_err and return to IDLE.
REQ-017 START_WAIT: line released; after TURN_US*CLK_MHZ cycles of line high -> RESP_LOW; line low seen here -> START_LOW with counter restarted.
REQ-018 On entry to RESP_LOW, SHALL latch the 40-bit payload; sensor_data changes afterwards do not affect the frame.
REQ-019 RESP_LOW drives 0 for exactly 80*CLK_MHZ cycles; RESP_HIGH releases for exactly 80*CLK_MHZ cycles.
REQ-020 Each bit: BIT_LOW drives 0 for 50*CLK_MHZ cycles; BIT_HIGH releases for 27*CLK_MHZ cycles (bit 0) or 70*CLK_MHZ cycles (bit 1).
REQ-021 Bits SHALL go MSB first: payload[39] first, payload[0] last; a 6-bit index counts 0..39.
REQ-022 After bit 40's high phase, END_LOW drives 0 for 50*CLK_MHZ cycles, then DONE releases, pulses frame_done, returns to IDLE next cycle.
REQ-023 After DONE, a new frame SHALL require the line to be seen high in IDLE before a low is treated as a start.
REQ-024 Bus activity during RESP_LOW..END_LOW SHALL be ignored; enable deassertion mid-frame does not abort the frame.
REQ-025 DTH SHALL be driven low only in RESP_LOW, BIT_LOW, END_LOW.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, counter=0, bit index=0, latched payload=0, busy=0, frame_done=0, start_err=0.
REQ-027 Reset mid-frame SHALL release DTH on the first edge with rst=1; no partial-frame pulses follow.

Configuration
REQ-028 Macro DHT_RESP_CHECKSUM_EN: when defined, transmitted byte [7:0] SHALL be the 8-bit wrapping sum of the four upper latched bytes, ignoring sensor_data[7:0].
REQ-029 Without DHT_RESP_CHECKSUM_EN, sensor_data[7:0] SHALL be transmitted as latched.

Verification
REQ-030 sensor_data=0x3500180053, enable=1, host low 18 ms then release -> 80 us low, 80 us high, 40 bits decoding 0x3500180053, frame_done once.
REQ-031 Host low 10 ms then release -> start_err pulses once, DTH never driven, busy returns to 0.
REQ-032 With DHT_RESP_CHECKSUM_EN, sensor_data=0x3500180000 -> checksum byte on wire 0x4D; without the macro -> 0x00.
REQ-033 Bit timing, CLK_MHZ=100: a 0 bit high lasts 2700 cycles, a 1 bit high 7000 cycles, every bit low 5000 cycles.
REQ-034 rst asserted during bit 20 -> DTH high-Z next edge, busy=0, frame_done stays 0; next valid start yields a full correct frame.
REQ-035 enable=0 with host 18 ms low -> no response, busy stays 0, no start_err.

Source files
------------

// File: rtl/dht_responder.sv
// dht_responder: DHT11/DHT22-style single-wire sensor emulator (open-drain DTH).
// Build option DHT_RESP_CHECKSUM_EN: send a computed checksum byte in place of sensor_data[7:0].
module dht_responder #(
  parameter int CLK_MHZ      = 100,
  parameter int START_MIN_US = 18000,
  parameter int TURN_US      = 30
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         DTH,
  input  logic        enable,
  input  logic [39:0] sensor_data,
  output logic        busy,
  output logic        frame_done,
  output logic        start_err
);

  localparam logic [20:0] START_CYC = 21'(START_MIN_US * CLK_MHZ);
  localparam logic [20:0] TURN_LAST = 21'(TURN_US * CLK_MHZ - 1);
  localparam logic [20:0] RESP_LAST = 21'(80 * CLK_MHZ - 1);
  localparam logic [20:0] LOW_LAST  = 21'(50 * CLK_MHZ - 1);
  localparam logic [20:0] ZERO_LAST = 21'(27 * CLK_MHZ - 1);
  localparam logic [20:0] ONE_LAST  = 21'(70 * CLK_MHZ - 1);

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    START_WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW,
    DONE
  } state_t;

  state_t      state;
  state_t      nxt;
  logic        sync1;
  logic        line;
  logic [20:0] cnt;
  logic [20:0] cnt_inc;
  logic [5:0]  idx;
  logic [5:0]  bit_pos;
  logic [39:0] payload;
  logic [39:0] latch_val;
  logic        cur_bit;
  logic        drv_low;
  logic        armed;

`ifdef DHT_RESP_CHECKSUM_EN
  logic [7:0] chk_sum;

  always_comb begin
    chk_sum = sensor_data[39:32] + sensor_data[31:24]
            + sensor_data[23:16] + sensor_data[15:8];
    latch_val = {sensor_data[39:8], chk_sum};
  end
`else
  assign latch_val = sensor_data;
`endif

  assign cnt_inc = (&cnt) ? cnt : cnt + 21'd1;
  assign bit_pos = 6'd39 - idx;
  assign cur_bit = payload[bit_pos];

  // open-drain: only ever pull low or release
  assign DTH = drv_low ? 1'b0 : 1'bz;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (!line && armed && enable) nxt = START_LOW;
      START_LOW:
        if (line) nxt = (cnt >= START_CYC) ? START_WAIT : IDLE;
      START_WAIT:
        if (!line) nxt = START_LOW;
        else if (cnt == TURN_LAST) nxt = RESP_LOW;
      RESP_LOW:
        if (cnt == RESP_LAST) nxt = RESP_HIGH;
      RESP_HIGH:
        if (cnt == RESP_LAST) nxt = BIT_LOW;
      BIT_LOW:
        if (cnt == LOW_LAST) nxt = BIT_HIGH;
      BIT_HIGH:
        if (cnt == (cur_bit ? ONE_LAST : ZERO_LAST))
          nxt = (idx == 6'd39) ? END_LOW : BIT_LOW;
      END_LOW:
        if (cnt == LOW_LAST) nxt = DONE;
      DONE:
        nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      line       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      payload    <= '0;
      drv_low    <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      sync1      <= DTH;
      line       <= sync1;
      state      <= nxt;
      cnt        <= (nxt != state) ? '0 : cnt_inc;
      busy       <= (nxt != IDLE);
      frame_done <= (nxt == DONE);
      start_err  <= (state == START_LOW) && (nxt == IDLE);
      drv_low    <= (nxt == RESP_LOW) || (nxt == BIT_LOW)
                 || (nxt == END_LOW);
      if (state != RESP_LOW && nxt == RESP_LOW) begin
        payload <= latch_val;
        idx     <= '0;
      end
      if (state == BIT_HIGH && nxt == BIT_LOW)
        idx <= idx + 6'd1;
      // a fresh start needs the line seen high after the previous frame
      if (nxt == DONE)
        armed <= 1'b0;
      else if (state == IDLE && line)
        armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dht_responder.sv
// tb_dht_responder: directed host transactions with a queued scoreboard.
// A wire decoder rebuilds each frame from DTH run lengths and checks it on frame_done.
`timescale 1ns/1ps
module tb_dht_responder;

  localparam int M    = 2;
  localparam int SMIN = 100;
  localparam int TURN = 30;

`ifdef DHT_RESP_CHECKSUM_EN
  localparam logic [39:0] EXP1 = 40'h350018004D;
  localparam logic [39:0] EXP2 = 40'h350018004D;
  localparam logic [39:0] EXP4 = 40'hA55AFF00FE;
`else
  localparam logic [39:0] EXP1 = 40'h3500180053;
  localparam logic [39:0] EXP2 = 40'h3500180000;
  localparam logic [39:0] EXP4 = 40'hA55AFF00C3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        host_low = 1'b0;
  logic [39:0] sensor_data = '0;
  logic        busy;
  logic        frame_done;
  logic        start_err;
  wire         dth;

  pullup (dth);
  assign dth = host_low ? 1'b0 : 1'bz;

  dht_responder #(
    .CLK_MHZ(M),
    .START_MIN_US(SMIN),
    .TURN_US(TURN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DTH(dth),
    .enable(enable),
    .sensor_data(sensor_data),
    .busy(busy),
    .frame_done(frame_done),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_frame;
    logic [39:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   runs_len[128];
  bit   runs_lvl[128];
  int   nruns = 0;
  logic prev_lvl = 1'b1;
  int   run_len = 0;
  bit   skip = 1'b1;
  int   dut_lows = 0;
  int   busy_cnt = 0;
  exp_t e;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input logic [39:0] exp_data);
    logic [39:0] got;
    int bad;
    int lo;
    int hi;
    got = '0;
    bad = 0;
    for (int b = 0; b < 40; b++) begin
      lo  = runs_len[3 + 2 * b];
      hi  = runs_len[4 + 2 * b];
      got = {got[38:0], (hi > (97 * M) / 2)};
      if (lo != 50 * M || runs_lvl[3 + 2 * b]) bad++;
      if (hi != 27 * M && hi != 70 * M) bad++;
    end
    if (runs_len[0] < TURN * M) bad++;
    if (runs_len[1] != 80 * M || runs_lvl[1]) bad++;
    if (runs_len[2] != 80 * M || !runs_lvl[2]) bad++;
    if (runs_len[83] != 50 * M || runs_lvl[83]) bad++;
    chk("frame_runs", nruns, 84);
    chk("frame_data", got, exp_data);
    chk("frame_timing_errs", bad, 0);
  endtask

  // wire decoder + scoreboard monitor
  always @(negedge clk) begin
    if (host_low) begin
      nruns = 0;
      skip  = 1'b1;
    end
    if (dth === prev_lvl) run_len++;
    else begin
      if (!skip && nruns < 128) begin
        runs_lvl[nruns] = prev_lvl;
        runs_len[nruns] = run_len;
        nruns++;
      end
      if (!host_low) skip = 1'b0;
      prev_lvl = dth;
      run_len  = 1;
    end
    if (rst) begin
      nruns = 0;
      skip  = 1'b1;
    end
    if (!host_low && dth !== 1'b1) dut_lows++;
    if (busy) busy_cnt++;
    if (start_err) begin
      chk("start_err_queued", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("start_err_kind", e.is_frame, 0);
      end
    end
    if (frame_done) begin
      chk("frame_done_queued", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_done_kind", e.is_frame, 1);
        if (e.is_frame) check_frame(e.data);
      end
    end
  end

  task automatic host_start(input int n);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_drained"}, i < budget, 1);
  endtask

  task automatic wait_runs(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (nruns < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_reached"}, i < budget, 1);
  endtask

  int lows0;
  int busy0;

  initial begin
    sensor_data = 40'h3500180053;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_start_err", start_err, 0);
    chk("rst_dth", dth, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    enable = 1'b1;
    repeat (5) @(posedge clk);

    exp_q.push_back('{1'b1, EXP1});
    host_start(300);
    drain("frame1", 20000);

    lows0 = dut_lows;
    exp_q.push_back('{1'b0, 40'h0});
    host_start(120);
    drain("short", 1000);
    chk("short_no_drive", dut_lows - lows0, 0);
    chk("short_busy", busy, 0);

    enable = 1'b0;
    lows0 = dut_lows;
    busy0 = busy_cnt;
    host_start(300);
    repeat (200) @(posedge clk);
    chk("dis_busy_cycles", busy_cnt - busy0, 0);
    chk("dis_no_drive", dut_lows - lows0, 0);
    enable = 1'b1;
    repeat (5) @(posedge clk);

    sensor_data = 40'h3500180000;
    exp_q.push_back('{1'b1, EXP2});
    host_start(300);
    wait_runs("f2_resp", 3, 2000);
    sensor_data = 40'hFFFFFFFFFF;
    enable = 1'b0;
    drain("frame2", 20000);
    enable = 1'b1;
    repeat (5) @(posedge clk);

    sensor_data = 40'hA55AFF00C3;
    host_start(300);
    wait_runs("f3_bit20", 43, 10000);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dth", dth, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_frame_done", frame_done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lows0 = dut_lows;
    repeat (300) @(posedge clk);
    chk("midrst_no_drive", dut_lows - lows0, 0);

    exp_q.push_back('{1'b1, EXP4});
    host_start(300);
    drain("frame4", 20000);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
